// File: rtl/interrupt_request_unit_if.sv
// interrupt_request_unit_if: handshake between the interrupt request unit and the control unit
//   IF, INTACK          : fetch-boundary strobe and vector-read strobe from the control unit
//   rstReq, INTREQ      : reset-sequence and interrupt requests to CAR selection
//   intVec              : vector address for the current/pending sequence
//   irqAck, nmiAck      : one-cycle acknowledges to the serviced source
interface interrupt_request_unit_if #(parameter int NUM_IRQ = 14);
  logic IF, INTACK, rstReq, INTREQ, nmiAck;
  logic [15:0] intVec;
  logic [NUM_IRQ-1:0] irqAck;
  modport master (output IF, INTACK, input rstReq, INTREQ, intVec, irqAck, nmiAck);
  modport slave (input IF, INTACK, output rstReq, INTREQ, intVec, irqAck, nmiAck);
endinterface

// File: rtl/interrupt_request_unit.sv
// interrupt_request_unit: turns reset, PUC, NMI and prioritized maskable requests into one rstReq/INTREQ handshake
//   clk, rst_n          : clock, asynchronous active-low reset
//   swRst               : synchronous software reset (PUC)
//   GIE, NMIE           : global interrupt enable, NMI enable
//   nmi                 : rising-edge NMI source
//   irq                 : level maskable requests, higher index wins
//   bus                 : control-unit handshake (IF, INTACK in; rstReq, INTREQ, intVec, irqAck, nmiAck out)
module interrupt_request_unit #(
  parameter int NUM_IRQ = 14,
  parameter logic [15:0] NMI_VEC = 16'hFFFC,
  parameter logic [15:0] RST_VEC = 16'hFFFE
) (
  input logic clk,
  input logic rst_n,
  input logic swRst,
  input logic GIE,
  input logic NMIE,
  input logic nmi,
  input logic [NUM_IRQ-1:0] irq,
  interrupt_request_unit_if.slave bus
);
  localparam int IW = $clog2(NUM_IRQ);
  typedef enum logic [1:0] {RESET, IDLE, PEND, SERVICE} state_t;
  state_t state, state_n;
  logic [IW-1:0] sel, sel_n, idx;
  logic sel_nmi, sel_nmi_n, nmi_pend, nmi_pend_n, nmi_d, hit;
  logic rst_req_n, intreq_n, nmi_ack_n;
  logic [15:0] vec_n;
  logic [NUM_IRQ-1:0] irq_ack_n;
  // ascending scan so the highest qualified index is the one left standing
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (GIE && irq[i]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
  always_comb begin
    state_n = state;
    sel_n = sel;
    sel_nmi_n = sel_nmi;
    rst_req_n = bus.rstReq;
    intreq_n = bus.INTREQ;
    vec_n = bus.intVec;
    irq_ack_n = '0;
    nmi_ack_n = 1'b0;
    // a new edge in the same cycle as the NMI acknowledge keeps the pend set
    nmi_pend_n = (nmi & ~nmi_d & NMIE) | (nmi_pend & ~(state == SERVICE && sel_nmi && bus.INTACK));
    case (state)
      RESET: begin
        rst_req_n = 1'b1;
        vec_n = RST_VEC;
        if (bus.INTACK) begin
          rst_req_n = 1'b0;
          state_n = IDLE;
        end
      end
      IDLE:
        if (nmi_pend || hit) begin
          sel_nmi_n = nmi_pend;
          sel_n = nmi_pend ? sel : idx;
          vec_n = nmi_pend ? NMI_VEC : 16'hFFE0 + {{(15-IW){1'b0}}, idx, 1'b0};
          intreq_n = 1'b1;
          state_n = PEND;
        end
      PEND:
        if (bus.IF) begin
          intreq_n = 1'b0;
          state_n = SERVICE;
        end else if (!sel_nmi && !(irq[sel] && GIE)) begin
          intreq_n = 1'b0;
          state_n = IDLE;
        end
      default:
        if (bus.INTACK) begin
          nmi_ack_n = sel_nmi;
          irq_ack_n[sel] = !sel_nmi;
          state_n = IDLE;
        end
    endcase
    if (swRst) begin
      state_n = RESET;
      rst_req_n = 1'b1;
      intreq_n = 1'b0;
      vec_n = RST_VEC;
      irq_ack_n = '0;
      nmi_ack_n = 1'b0;
      nmi_pend_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RESET;
      sel <= '0;
      sel_nmi <= 1'b0;
      nmi_pend <= 1'b0;
      nmi_d <= 1'b0;
      bus.rstReq <= 1'b1;
      bus.INTREQ <= 1'b0;
      bus.intVec <= RST_VEC;
      bus.irqAck <= '0;
      bus.nmiAck <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      sel_nmi <= sel_nmi_n;
      nmi_pend <= nmi_pend_n;
      nmi_d <= nmi;
      bus.rstReq <= rst_req_n;
      bus.INTREQ <= intreq_n;
      bus.intVec <= vec_n;
      bus.irqAck <= irq_ack_n;
      bus.nmiAck <= nmi_ack_n;
    end
endmodule

// File: tb/tb_interrupt_request_unit.sv
// tb_interrupt_request_unit: directed scenarios plus randomized run against a behavioural model
module tb_interrupt_request_unit;
  logic clk = 1'b0, rst_n = 1'b1, sw_rst = 1'b0, gie = 1'b0, nmie = 1'b0, nmi = 1'b0;
  logic [13:0] irq = '0;
  int total = 0, bad = 0;
  interrupt_request_unit_if #(.NUM_IRQ(14)) bus();
  interrupt_request_unit #(.NUM_IRQ(14)) dut (
    .clk(clk), .rst_n(rst_n), .swRst(sw_rst), .GIE(gie), .NMIE(nmie), .nmi(nmi), .irq(irq), .bus(bus)
  );
  always #5 clk = ~clk;
  // model: in_reset, phase 0=idle 1=waiting for IF 2=serving, m_sel=-1 means NMI
  bit m_rst, m_req, m_nack, m_np, m_nprev;
  int m_phase, m_sel;
  logic [15:0] m_vec;
  logic [13:0] m_ack;
  task automatic model_reset();
    m_rst = 1; m_phase = 0; m_req = 0; m_vec = 16'hFFFE; m_ack = '0; m_nack = 0; m_np = 0; m_nprev = 0; m_sel = 0;
  endtask
  task automatic model_update();
    bit edge_s, was_np;
    edge_s = nmi && !m_nprev && nmie;
    was_np = m_np;
    m_ack = '0;
    m_nack = 0;
    m_nprev = nmi;
    if (sw_rst) begin
      m_rst = 1; m_phase = 0; m_req = 0; m_vec = 16'hFFFE; m_np = 0;
      return;
    end
    m_np = edge_s || (was_np && !(!m_rst && m_phase == 2 && m_sel < 0 && bus.INTACK));
    if (m_rst) begin
      if (bus.INTACK) m_rst = 0;
    end else if (m_phase == 0) begin
      if (was_np) begin
        m_sel = -1; m_vec = 16'hFFFC; m_req = 1; m_phase = 1;
      end else if (gie && irq != 0) begin
        for (int i = 13; i >= 0; i--) if (irq[i]) begin m_sel = i; break; end
        m_vec = 16'hFFE0 + 16'(2 * m_sel); m_req = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (bus.IF) begin m_req = 0; m_phase = 2; end
      else if (m_sel >= 0 && !(irq[m_sel] && gie)) begin m_req = 0; m_phase = 0; end
    end else if (bus.INTACK) begin
      if (m_sel < 0) m_nack = 1; else m_ack[m_sel] = 1'b1;
      m_phase = 0;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset(); else model_update();
  endtask
  task automatic test_reset();
    bus.IF = 0; bus.INTACK = 0;
    model_reset();
    #1 rst_n = 0;
    #1;
    total++; if (bus.rstReq !== 1'b1) begin bad++; $display("FAIL por_rstReq got=%b want=1", bus.rstReq); end
    total++; if (bus.INTREQ !== 1'b0) begin bad++; $display("FAIL por_INTREQ got=%b want=0", bus.INTREQ); end
    total++; if (bus.intVec !== 16'hFFFE) begin bad++; $display("FAIL por_intVec got=%h want=fffe", bus.intVec); end
    total++; if (bus.irqAck !== 14'h0 || bus.nmiAck !== 1'b0) begin bad++; $display("FAIL por_acks got=%h/%b want=0/0", bus.irqAck, bus.nmiAck); end
    tick(); tick();
    rst_n = 1;
    tick();
    total++; if (bus.rstReq !== 1'b1) begin bad++; $display("FAIL reset_hold got=%b want=1", bus.rstReq); end
    bus.INTACK = 1; tick(); bus.INTACK = 0;
    total++; if (bus.rstReq !== 1'b0) begin bad++; $display("FAIL reset_exit got=%b want=0", bus.rstReq); end
    gie = 1; irq = 14'h0004; tick();
    bus.IF = 1; tick(); bus.IF = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    total++; if (bus.rstReq !== 1'b1) begin bad++; $display("FAIL midsvc_rstReq got=%b want=1", bus.rstReq); end
    total++; if (bus.intVec !== 16'hFFFE) begin bad++; $display("FAIL midsvc_intVec got=%h want=fffe", bus.intVec); end
    total++; if (bus.INTREQ !== 1'b0) begin bad++; $display("FAIL midsvc_INTREQ got=%b want=0", bus.INTREQ); end
    tick();
    #2 rst_n = 1;
    irq = '0; bus.INTACK = 1; tick(); bus.INTACK = 0;
    total++; if (bus.rstReq !== 1'b0) begin bad++; $display("FAIL midsvc_exit got=%b want=0", bus.rstReq); end
    total++; if (bus.irqAck !== 14'h0 || bus.nmiAck !== 1'b0) begin bad++; $display("FAIL midsvc_noack got=%h/%b want=0/0", bus.irqAck, bus.nmiAck); end
    tick();
  endtask
  task automatic test_priority();
    gie = 1; irq = 14'h0005; tick();
    total++; if (bus.INTREQ !== 1'b1 || bus.intVec !== 16'hFFE4) begin bad++; $display("FAIL prio_sel got=%b/%h want=1/ffe4", bus.INTREQ, bus.intVec); end
    bus.IF = 1; tick(); bus.IF = 0;
    total++; if (bus.INTREQ !== 1'b0) begin bad++; $display("FAIL prio_commit got=%b want=0", bus.INTREQ); end
    bus.INTACK = 1; tick();
    total++; if (bus.irqAck !== 14'h0004 || bus.INTREQ !== 1'b0) begin bad++; $display("FAIL prio_ack got=%h/%b want=0004/0", bus.irqAck, bus.INTREQ); end
    bus.INTACK = 0; irq = 14'h0001; tick();
    total++; if (bus.irqAck !== 14'h0) begin bad++; $display("FAIL prio_ack_len got=%h want=0000", bus.irqAck); end
    total++; if (bus.INTREQ !== 1'b1 || bus.intVec !== 16'hFFE0) begin bad++; $display("FAIL prio_next got=%b/%h want=1/ffe0", bus.INTREQ, bus.intVec); end
    bus.IF = 1; tick(); bus.IF = 0;
    bus.INTACK = 1; irq = '0; tick(); bus.INTACK = 0;
    total++; if (bus.irqAck !== 14'h0001) begin bad++; $display("FAIL prio_ack0 got=%h want=0001", bus.irqAck); end
    tick();
  endtask
  task automatic test_nmi_over_maskable();
    nmie = 1; gie = 1; nmi = 1; irq = 14'h2000; tick();
    total++; if (bus.INTREQ !== 1'b1 || bus.intVec !== 16'hFFFA) begin bad++; $display("FAIL nmiov_first got=%b/%h want=1/fffa", bus.INTREQ, bus.intVec); end
    bus.IF = 1; tick(); bus.IF = 0;
    bus.INTACK = 1; irq = '0; tick(); bus.INTACK = 0;
    total++; if (bus.irqAck !== 14'h2000 || bus.nmiAck !== 1'b0) begin bad++; $display("FAIL nmiov_ack13 got=%h/%b want=2000/0", bus.irqAck, bus.nmiAck); end
    tick();
    total++; if (bus.INTREQ !== 1'b1 || bus.intVec !== 16'hFFFC) begin bad++; $display("FAIL nmiov_second got=%b/%h want=1/fffc", bus.INTREQ, bus.intVec); end
    bus.IF = 1; tick(); bus.IF = 0;
    bus.INTACK = 1; tick(); bus.INTACK = 0;
    total++; if (bus.nmiAck !== 1'b1 || bus.irqAck !== 14'h0) begin bad++; $display("FAIL nmiov_nmiack got=%b/%h want=1/0000", bus.nmiAck, bus.irqAck); end
    nmi = 0; tick();
    total++; if (bus.nmiAck !== 1'b0 || bus.INTREQ !== 1'b0) begin bad++; $display("FAIL nmiov_after got=%b/%b want=0/0", bus.nmiAck, bus.INTREQ); end
  endtask
  task automatic test_nmi_gating();
    int n1 = 0, n2 = 0;
    gie = 0; nmie = 1; bus.IF = 1; bus.INTACK = 1;
    for (int c = 0; c < 20; c++) begin nmi = (c < 5); tick(); if (bus.nmiAck) n1++; end
    total++; if (n1 != 1) begin bad++; $display("FAIL nmi_once got=%0d want=1", n1); end
    nmie = 0;
    for (int c = 0; c < 10; c++) begin nmi = (c < 3); tick(); if (bus.nmiAck) n2++; end
    nmie = 1;
    for (int c = 0; c < 10; c++) begin nmi = 0; tick(); if (bus.nmiAck) n2++; end
    total++; if (n2 != 0) begin bad++; $display("FAIL nmi_masked got=%0d want=0", n2); end
    bus.IF = 0; bus.INTACK = 0; tick();
  endtask
  task automatic test_withdrawal();
    gie = 1; irq = 14'h0008; tick();
    total++; if (bus.INTREQ !== 1'b1 || bus.intVec !== 16'hFFE6) begin bad++; $display("FAIL wd_sel got=%b/%h want=1/ffe6", bus.INTREQ, bus.intVec); end
    gie = 0; tick();
    total++; if (bus.INTREQ !== 1'b0) begin bad++; $display("FAIL wd_drop got=%b want=0", bus.INTREQ); end
    tick();
    total++; if (bus.INTREQ !== 1'b0 || bus.irqAck !== 14'h0) begin bad++; $display("FAIL wd_stay got=%b/%h want=0/0000", bus.INTREQ, bus.irqAck); end
    gie = 1; tick();
    total++; if (bus.INTREQ !== 1'b1) begin bad++; $display("FAIL wd_rearb got=%b want=1", bus.INTREQ); end
    gie = 0; bus.IF = 1; tick(); bus.IF = 0;
    bus.INTACK = 1; tick(); bus.INTACK = 0;
    total++; if (bus.irqAck !== 14'h0008) begin bad++; $display("FAIL wd_if_wins got=%h want=0008", bus.irqAck); end
    irq = '0; gie = 1; tick();
  endtask
  task automatic test_puc();
    nmie = 1; nmi = 1; tick();
    nmi = 0; tick();
    total++; if (bus.INTREQ !== 1'b1 || bus.intVec !== 16'hFFFC) begin bad++; $display("FAIL puc_pend got=%b/%h want=1/fffc", bus.INTREQ, bus.intVec); end
    sw_rst = 1; nmi = 1; tick(); sw_rst = 0;
    total++; if (bus.rstReq !== 1'b1 || bus.INTREQ !== 1'b0 || bus.intVec !== 16'hFFFE) begin bad++; $display("FAIL puc_state got=%b/%b/%h want=1/0/fffe", bus.rstReq, bus.INTREQ, bus.intVec); end
    bus.INTACK = 1; tick(); bus.INTACK = 0;
    total++; if (bus.rstReq !== 1'b0 || bus.nmiAck !== 1'b0) begin bad++; $display("FAIL puc_exit got=%b/%b want=0/0", bus.rstReq, bus.nmiAck); end
    tick(); tick();
    total++; if (bus.INTREQ !== 1'b0) begin bad++; $display("FAIL puc_nmi_dropped got=%b want=0", bus.INTREQ); end
    nmi = 0; tick();
  endtask
  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      sw_rst = $urandom_range(0, 59) == 0;
      gie = $urandom_range(0, 7) != 0;
      nmie = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 5) == 0) nmi = ~nmi;
      if ($urandom_range(0, 3) == 0) irq = 14'($urandom & $urandom & $urandom);
      bus.IF = $urandom_range(0, 2) == 0;
      bus.INTACK = $urandom_range(0, 2) == 0;
      tick();
      total++; if (bus.rstReq !== m_rst) begin bad++; $display("FAIL rnd_rstReq c=%0d got=%b want=%b", c, bus.rstReq, m_rst); end
      total++; if (bus.INTREQ !== m_req) begin bad++; $display("FAIL rnd_INTREQ c=%0d got=%b want=%b", c, bus.INTREQ, m_req); end
      total++; if (bus.intVec !== m_vec) begin bad++; $display("FAIL rnd_intVec c=%0d got=%h want=%h", c, bus.intVec, m_vec); end
      total++; if (bus.irqAck !== m_ack) begin bad++; $display("FAIL rnd_irqAck c=%0d got=%h want=%h", c, bus.irqAck, m_ack); end
      total++; if (bus.nmiAck !== m_nack) begin bad++; $display("FAIL rnd_nmiAck c=%0d got=%b want=%b", c, bus.nmiAck, m_nack); end
    end
  endtask
  initial begin
    test_reset();
    test_priority();
    test_nmi_over_maskable();
    test_nmi_gating();
    test_withdrawal();
    test_puc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/interrupt_request_unit.md
# interrupt_request_unit

Sequencer that sits ahead of the CPU's CAR next-state selection and owns the reset/interrupt request lines it consumes. It turns reset, software reset (PUC), edge-triggered NMI and prioritized level-sensitive maskable requests into a single `rstReq` / `INTREQ` handshake with the control unit. It holds the selected vector address for the interrupt microsequence to load into PC, and pulses a per-source acknowledge when the microsequence consumes that vector.

## Interface
- `NUM_IRQ`, 14: maskable request lines; line i has vector 16'hFFE0 + 2*i; higher index = higher priority.
- `NMI_VEC`, 16'hFFFC: NMI vector address.
- `RST_VEC`, 16'hFFFE: reset/PUC vector address.

- `clk` input 1: system clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `swRst` input 1: synchronous software reset (PUC) request, level.
- `GIE` input 1: global interrupt enable from SR.
- `NMIE` input 1: NMI enable.
- `nmi` input 1: NMI source, synchronous to `clk`, rising-edge sensitive.
- `irq` input NUM_IRQ: maskable requests, level, synchronous.
- `IF` input 1: instruction-fetch boundary strobe from control unit.
- `INTACK` input 1: one-cycle strobe from the interrupt microsequence when the vector is read.
- `rstReq` output 1: reset-sequence request to CAR selection (highest priority).
- `INTREQ` output 1: interrupt request to CAR selection (taken when `IF` is high).
- `intVec` output 16: vector address for the current/pending sequence.
- `irqAck` output NUM_IRQ: one-hot, one-cycle acknowledge to the serviced maskable source.
- `nmiAck` output 1: one-cycle acknowledge for a serviced NMI.

## Operation
- States: RESET, IDLE, PEND, SERVICE. All outputs are registered.
- `rst_n` low, asynchronously: state RESET, `rstReq`=1, `INTREQ`=0, `intVec`=RST_VEC, `irqAck`=0, `nmiAck`=0, `nmiPend`=0, `nmi_d`=0.
- RESET:
  - Hold `rstReq`=1 and `intVec`=RST_VEC.
  - On `INTACK`, go to IDLE with `rstReq`=0.
  - `IF` is ignored.
- `swRst` high at any edge, in any state, forces RESET with the same values as async reset, except `nmi_d` keeps tracking. It overrides every other event in that cycle. No acks are issued for aborted sequences.
- NMI detection:
  - `nmi_d` <= `nmi` every cycle.
  - `nmiPend` sets on `nmi & ~nmi_d & NMIE`.
  - It clears on an NMI `INTACK`. A set in the same cycle wins.
- Priority in IDLE: `nmiPend` > `irq[NUM_IRQ-1]` > … > `irq[0]`. Maskable lines count only when `GIE`=1.
- IDLE: if any qualified source, latch its index/type and vector into `intVec`, set `INTREQ`=1, go to PEND.
- PEND:
  - The selection is frozen; later higher-priority arrivals wait.
  - Withdraw rule: if the selection is maskable and, with `IF`=0, `irq[sel]`=0 or `GIE`=0, set `INTREQ`=0 and go to IDLE. Re-arbitration starts the following cycle.
  - An NMI selection is never withdrawn.
  - `IF`=1 (with `INTREQ`=1) commits: set `INTREQ`=0, go to SERVICE. `IF` beats withdrawal in the same cycle.
- SERVICE:
  - `intVec` is held.
  - On `INTACK`: pulse `irqAck[sel]` or `nmiAck` for exactly one cycle and go to IDLE.
- `INTACK` outside RESET/SERVICE is ignored.

## Timing
- Maskable: `irq[i]`&`GIE` sampled high at edge k in IDLE → `INTREQ`=1 and `intVec` valid after edge k.
- NMI: `nmi` first sampled high at edge k → `nmiPend` after k → `INTREQ` after k+1.
- `IF` at edge k in PEND → `INTREQ`=0 after k.
- `INTACK` at edge k in SERVICE → ack pulse after k, cleared after k+1. The earliest next `INTREQ` is after k+1, a one-cycle IDLE gap.
- `rstReq` deasserts the cycle after `INTACK` in RESET.
- `rst_n` rising: first evaluation at the next `clk` edge; no output changes until then.

## Test plan
- **Reset sequence.** Pulse `rst_n` low mid-SERVICE, then release.
  - `rstReq`=1, `intVec`=FFFE, `INTREQ`=0 immediately.
  - `INTACK` → `rstReq`=0 next cycle, IDLE; no `irqAck`/`nmiAck` pulse.
- **Priority.** `GIE`=1, `irq`=14'h0005 at edge k.
  - `INTREQ`=1, `intVec`=FFE4 after k.
  - `IF` then `INTACK` → `irqAck`=14'h0004 for one cycle.
  - Next `INTREQ` has `intVec`=FFE0 two cycles after `INTACK`.
- **NMI over maskable.** `nmi` rises and `irq[13]`=1 in the same cycle with `GIE`=1.
  - `irq[13]` is selected first (NMI not yet pending), `intVec`=FFFA.
  - After it is serviced, `intVec`=FFFC, and `nmiAck` pulses on its `INTACK`.
- **NMI gating.** `nmi` held high for 5 cycles → exactly one NMI service. With `NMIE`=0 the edge is ignored permanently.
- **Withdrawal.** In PEND for `irq[3]`, drop `GIE` with `IF`=0 → `INTREQ`=0 next cycle, no ack.
  - Repeat with `GIE` drop and `IF`=1 in the same cycle → committed to SERVICE.
- **PUC.** `swRst`=1 in PEND for NMI → RESET, `intVec`=FFFE, `nmiPend` cleared; an NMI edge arriving in the same cycle is discarded.
